// File: rtl/conv1d_frame_ctrl.sv
// Frame-level sequencer for the streaming Conv1D datapath.
// Provides the ap_ctrl_chain handshake, gates input-FIFO reads, counts
// inputs/outputs per frame, bounds the pipeline drain and issues a
// one-cycle datapath flush between frames. Protocol violations are
// recorded in a sticky error vector that only reset clears.
module conv1d_frame_ctrl #(
  parameter int unsigned NIN           = 128,
  parameter int unsigned NOUT          = 97,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned FRAME_W       = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  input  logic               ap_continue,
  output logic               ap_ready,
  output logic               ap_done,
  output logic               ap_idle,
  input  logic               in_empty_n,
  input  logic               in_read_req,
  output logic               in_read,
  output logic               dp_enable,
  output logic               dp_flush,
  input  logic               dp_out_write,
  input  logic               out_full_n,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [3:0]         err
);

  localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(NIN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(NOUT - 1);
  localparam logic [CNT_W-1:0] OUT_ALL  = CNT_W'(NOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  // Bit positions inside err
  localparam int unsigned ERR_OVERRUN   = 0;
  localparam int unsigned ERR_EARLY_OUT = 1;
  localparam int unsigned ERR_EXTRA_OUT = 2;
  localparam int unsigned ERR_TIMEOUT   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             start_acc;
  logic             active;
  logic             rd_fire;
  logic             last_in;
  logic             out_sat;
  logic             out_acc;
  logic             out_hit;
  logic             tmo_hit;
  logic [3:0]       err_set;

  // Event decode shared by the FSM, the counters and the error logic
  assign start_acc = (state == S_IDLE) && ap_start;
  assign active    = (state == S_RUN) || (state == S_DRAIN);
  assign rd_fire   = (state == S_RUN) && in_read_req && in_empty_n;
  assign last_in   = rd_fire && (in_cnt == IN_LAST);
  assign out_sat   = (out_cnt == OUT_ALL);
  assign out_acc   = active && dp_out_write && !out_sat;
  assign out_hit   = out_acc && (out_cnt == OUT_LAST);
  assign tmo_hit   = (state == S_DRAIN) && !dp_out_write && (tmo_cnt == TMO_LAST);

  // Error events raised this cycle; writes outside RUN/DRAIN or past NOUT are extras
  always_comb begin
    err_set                = '0;
    err_set[ERR_OVERRUN]   = active && dp_out_write && !out_full_n;
    err_set[ERR_EARLY_OUT] = (state == S_RUN) && out_hit && !last_in;
    err_set[ERR_EXTRA_OUT] = dp_out_write && (!active || out_sat);
    err_set[ERR_TIMEOUT]   = tmo_hit;
  end

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake/datapath controls
  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    dp_enable = 1'b0;
    dp_flush  = 1'b0;
    in_read   = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        dp_enable = 1'b1;
        in_read   = rd_fire;
        if (last_in) begin
          // Outputs already complete (or completing now) skip the drain
          state_nxt = (out_hit || out_sat) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        dp_enable = 1'b1;
        if (out_hit || tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        if (ap_continue) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        dp_flush  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Input sample counter, cleared when a frame is accepted
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      in_cnt <= '0;
    end else if (start_acc) begin
      in_cnt <= '0;
    end else if (rd_fire) begin
      in_cnt <= in_cnt + CNT_W'(1);
    end
  end

  // Output write counter, saturating at NOUT
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_cnt <= '0;
    end else if (start_acc) begin
      out_cnt <= '0;
    end else if (out_acc) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Drain watchdog: consecutive DRAIN cycles without an output write
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      tmo_cnt <= '0;
    end else if ((state != S_DRAIN) || dp_out_write) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // One-cycle ready pulse after the last input of the frame is read
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ap_ready <= 1'b0;
    end else begin
      ap_ready <= last_in;
    end
  end

  // Completed-frame counter, advances when ap_done is acknowledged
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      frame_cnt <= '0;
    end else if ((state == S_DONE) && ap_continue) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  // Sticky error flags
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err <= '0;
    end else begin
      err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_conv1d_frame_ctrl.sv
// Self-checking bench for conv1d_frame_ctrl: randomized frame traffic
// checked every cycle against a frame-level behavioural model.
module tb_conv1d_frame_ctrl;

  localparam int NIN     = 128;
  localparam int NOUT    = 97;
  localparam int TMO     = 64;
  localparam int FRAME_W = 16;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;
  localparam int P_FLUSH = 4;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               ap_start;
  logic               ap_continue;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_idle;
  logic               in_empty_n;
  logic               in_read_req;
  logic               in_read;
  logic               dp_enable;
  logic               dp_flush;
  logic               dp_out_write;
  logic               out_full_n;
  logic [FRAME_W-1:0] frame_cnt;
  logic [3:0]         err;

  always #5 ap_clk = ~ap_clk;

  conv1d_frame_ctrl dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_continue  (ap_continue),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .in_empty_n   (in_empty_n),
    .in_read_req  (in_read_req),
    .in_read      (in_read),
    .dp_enable    (dp_enable),
    .dp_flush     (dp_flush),
    .dp_out_write (dp_out_write),
    .out_full_n   (out_full_n),
    .frame_cnt    (frame_cnt),
    .err          (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: frame phase, per-frame counts, expected flags
  int               m_ph;
  int               m_rd;
  int               m_wr;
  int               m_gap;
  int               m_done_cyc;
  logic [3:0]       m_err;
  logic [FRAME_W-1:0] m_frames;
  logic             m_ready;

  // Per-frame observations of DUT outputs
  int o_reads;
  int o_ready;
  int o_done;
  int o_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph       = P_IDLE;
    m_rd       = 0;
    m_wr       = 0;
    m_gap      = 0;
    m_done_cyc = 0;
    m_err      = '0;
    m_frames   = '0;
    m_ready    = 1'b0;
  endtask

  // Drive one clock cycle, check all outputs mid-cycle, advance the model
  task automatic cycle(input logic st, input logic rq, input logic em,
                       input logic wr, input logic fn, input logic ct);
    logic rd;
    logic lastin;
    ap_start     = st;
    in_read_req  = rq;
    in_empty_n   = em;
    dp_out_write = wr;
    out_full_n   = fn;
    ap_continue  = ct;
    @(negedge ap_clk);
    rd     = (m_ph == P_RUN) && rq && em;
    lastin = rd && (m_rd == NIN - 1);
    chk("ap_idle",   32'(ap_idle),   32'(m_ph == P_IDLE));
    chk("ap_done",   32'(ap_done),   32'(m_ph == P_DONE));
    chk("dp_enable", 32'(dp_enable), 32'((m_ph == P_RUN) || (m_ph == P_DRAIN)));
    chk("dp_flush",  32'(dp_flush),  32'(m_ph == P_FLUSH));
    chk("in_read",   32'(in_read),   32'(rd));
    chk("ap_ready",  32'(ap_ready),  32'(m_ready));
    chk("err",       32'(err),       32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    o_reads += int'(in_read);
    o_ready += int'(ap_ready);
    o_done  += int'(ap_done);
    o_flush += int'(dp_flush);

    // Output-write accounting and protocol errors
    if (wr) begin
      if ((m_ph == P_RUN) || (m_ph == P_DRAIN)) begin
        if (!fn) m_err[0] = 1'b1;
        if (m_wr == NOUT) begin
          m_err[2] = 1'b1;
        end else begin
          m_wr++;
          if ((m_ph == P_RUN) && (m_wr == NOUT) && !lastin) m_err[1] = 1'b1;
        end
      end else begin
        m_err[2] = 1'b1;
      end
    end
    m_ready = lastin;

    // Frame progression
    case (m_ph)
      P_IDLE: if (st) begin
        m_ph = P_RUN;
        m_rd = 0;
        m_wr = 0;
      end
      P_RUN: begin
        if (rd) m_rd++;
        if (lastin) begin
          m_ph       = (m_wr == NOUT) ? P_DONE : P_DRAIN;
          m_gap      = 0;
          m_done_cyc = 0;
        end
      end
      P_DRAIN: begin
        m_gap = wr ? 0 : m_gap + 1;
        if (m_wr == NOUT) begin
          m_ph       = P_DONE;
          m_done_cyc = 0;
        end else if (m_gap == TMO) begin
          m_err[3]   = 1'b1;
          m_ph       = P_DONE;
          m_done_cyc = 0;
        end
      end
      P_DONE: begin
        m_done_cyc++;
        if (ct) begin
          m_ph     = P_FLUSH;
          m_frames = m_frames + FRAME_W'(1);
        end
      end
      default: m_ph = P_IDLE;
    endcase
    @(posedge ap_clk);
    #1;
  endtask

  // Run one frame from IDLE back to IDLE with randomized traffic
  task automatic frame(input int p_req, input int p_emp, input int run_cap,
                       input int total, input bit coincide, input int cont_wait,
                       input int full_bad, input bit extra_done, input bit idle_wr);
    bit   started = 1'b0;
    int   budget  = 0;
    logic st, rq, em, wr, fn, ct;
    o_reads = 0;
    o_ready = 0;
    o_done  = 0;
    o_flush = 0;
    while (!(started && (m_ph == P_IDLE)) && (budget < 3000)) begin
      rq = ($urandom_range(99) < 32'(p_req));
      em = ($urandom_range(99) < 32'(p_emp));
      st = (m_ph == P_IDLE) ? !started : 1'($urandom_range(1));
      wr = 1'b0;
      case (m_ph)
        P_IDLE:  wr = idle_wr && !started;
        P_RUN: begin
          if (coincide)
            wr = (m_wr < NOUT - 1) || (rq && em && (m_rd == NIN - 1) && (m_wr == NOUT - 1));
          else
            wr = (m_wr < run_cap) && ($urandom_range(3) != 0);
        end
        P_DRAIN: wr = (m_wr < total) && ($urandom_range(3) != 0);
        P_DONE:  wr = extra_done && (m_done_cyc == 0);
        default: wr = 1'b0;
      endcase
      if (wr)
        fn = !(((m_ph == P_RUN) || (m_ph == P_DRAIN)) && (m_wr == full_bad));
      else
        fn = 1'($urandom_range(1));
      ct = (m_ph == P_DONE) ? (m_done_cyc >= cont_wait) : 1'($urandom_range(1));
      if ((m_ph == P_IDLE) && st) started = 1'b1;
      cycle(st, rq, em, wr, fn, ct);
      budget++;
    end
    chk("frame_in_budget", 32'(budget < 3000), 32'd1);
    chk("frame_reads",     32'(o_reads), 32'(NIN));
    chk("frame_ready",     32'(o_ready), 32'd1);
    chk("frame_done_len",  32'(o_done),  32'(cont_wait + 1));
    chk("frame_flush",     32'(o_flush), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    ap_rst       = 1'b1;
    ap_start     = 1'b0;
    ap_continue  = 1'b0;
    in_empty_n   = 1'b0;
    in_read_req  = 1'b0;
    dp_out_write = 1'b0;
    out_full_n   = 1'b1;
    model_reset();

    // Outputs while held in reset
    @(negedge ap_clk);
    chk("rst_idle",  32'(ap_idle),   32'd1);
    chk("rst_done",  32'(ap_done),   32'd0);
    chk("rst_ready", 32'(ap_ready),  32'd0);
    chk("rst_en",    32'(dp_enable), 32'd0);
    chk("rst_flush", 32'(dp_flush),  32'd0);
    chk("rst_read",  32'(in_read),   32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Nominal frame: continuous input, outputs during drain, immediate continue
    frame(100, 100, 0, NOUT, 1'b0, 0, -1, 1'b0, 1'b0);
    chk("nominal_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("nominal_err",       32'(err),       32'd0);
    chk("nominal_idle",      32'(ap_idle),   32'd1);

    // Back-pressure: sparse input, some outputs during RUN, continue delayed 10 cycles
    frame(80, 50, 30, NOUT, 1'b0, 10, -1, 1'b0, 1'b0);

    // Last input and last output in the same cycle: DRAIN skipped
    frame(100, 100, 0, NOUT, 1'b1, 2, -1, 1'b0, 1'b0);

    // Randomized clean frames
    for (int i = 0; i < 3; i++) begin
      frame(40 + int'($urandom_range(60)), 40 + int'($urandom_range(60)),
            int'($urandom_range(60)), NOUT, 1'b0, int'($urandom_range(5)),
            -1, 1'b0, 1'b0);
    end
    chk("clean_err", 32'(err), 32'd0);

    // Drain timeout: outputs stop at 90
    frame(100, 100, 0, 90, 1'b0, 3, -1, 1'b0, 1'b0);
    chk("timeout_err", 32'(err), 32'b1000);

    // Asynchronous reset in the middle of RUN after 40 reads
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    b = 0;
    while ((m_rd < 40) && (b < 200)) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      b++;
    end
    chk("midrun_reads", 32'(m_rd), 32'd40);
    #2;
    ap_rst = 1'b1;
    #1;
    model_reset();
    chk("arst_idle",  32'(ap_idle),   32'd1);
    chk("arst_read",  32'(in_read),   32'd0);
    chk("arst_en",    32'(dp_enable), 32'd0);
    chk("arst_err",   32'(err),       32'd0);
    chk("arst_frame", 32'(frame_cnt), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    frame(100, 100, 0, NOUT, 1'b0, 0, -1, 1'b0, 1'b0);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("post_rst_err",       32'(err),       32'd0);

    // Protocol errors, each sticky across later frames
    frame(100, 100, 0, NOUT, 1'b0, 0, 5, 1'b0, 1'b0);
    chk("overrun_err", 32'(err), 32'b0001);
    frame(100, 100, 0, NOUT, 1'b0, 1, -1, 1'b1, 1'b0);
    chk("extra_err", 32'(err), 32'b0101);
    frame(100, 50, NOUT, NOUT, 1'b0, 0, -1, 1'b0, 1'b0);
    chk("early_err", 32'(err), 32'b0111);
    frame(100, 100, 0, NOUT, 1'b0, 0, -1, 1'b0, 1'b1);
    chk("persist_err", 32'(err), 32'b0111);

    // Reset clears sticky errors
    ap_rst = 1'b1;
    #2;
    model_reset();
    chk("final_rst_err", 32'(err), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1d_frame_ctrl.md
Name: conv1d_frame_ctrl

Overview:
Frame-level sequencer for the streaming Conv1D datapath (NIN inputs -> NOUT outputs per frame). It implements the ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_idle/ap_continue) that the datapath leaves unimplemented, and gates input-FIFO reads. It counts inputs and outputs per frame, waits for the pipeline to drain, and issues a one-cycle datapath flush between frames. It sits between the top-level control interface and the conv datapath/reducer.

Parameters:
NIN, 128, input samples per frame
NOUT, 97, output samples per frame (NIN-KERNEL_SIZE+1)
CNT_W, 8, width of the input/output counters (must hold NIN)
DRAIN_TIMEOUT, 64, max cycles in DRAIN without an output write before abort
FRAME_W, 16, width of the frame counter

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous active-high reset
ap_start  in  1  start request for a frame
ap_continue  in  1  acknowledges ap_done
ap_ready  out  1  one-cycle pulse: last input of the frame accepted
ap_done  out  1  frame complete; held until ap_continue
ap_idle  out  1  high in IDLE
in_empty_n  in  1  input FIFO not empty
in_read_req  in  1  datapath wants a sample
in_read  out  1  gated FIFO read strobe
dp_enable  out  1  datapath may run (RUN or DRAIN)
dp_flush  out  1  one-cycle clear of shift register/valid pipeline
dp_out_write  in  1  datapath output write strobe
out_full_n  in  1  output FIFO not full
frame_cnt  out  FRAME_W  completed frames, wraps
err  out  4  sticky {timeout, extra_out, early_out, overrun}, cleared only by reset

Behaviour:
- States: IDLE, RUN, DRAIN, DONE, FLUSH. Registered state; ap_idle, ap_done, dp_enable, dp_flush and in_read are decoded combinationally from state and inputs.
- Reset (async, any state): state=IDLE, in_cnt=out_cnt=tmo_cnt=0, frame_cnt=0, err=0, ap_ready=0. Outputs under reset: ap_idle=1, all others 0.
- in_read = (state==RUN) & in_read_req & in_empty_n. It is never asserted outside RUN.
- IDLE: on ap_start=1 -> RUN (in_cnt, out_cnt cleared on entry). ap_start is sampled only in IDLE.
- RUN: each in_read increments in_cnt. When the NIN-th read occurs: ap_ready is a registered 1-cycle pulse on the next cycle, and the state goes to DRAIN. If the NOUT-th output occurs in that same cycle, the state goes to DONE directly.
- RUN/DRAIN: each dp_out_write increments out_cnt, saturating at NOUT.
  - A write while out_cnt==NOUT sets err.extra_out (it is not counted).
  - A write with out_full_n=0 sets err.overrun.
  - out_cnt reaching NOUT in RUN before in_cnt==NIN sets err.early_out; the state stays in RUN until the inputs complete, then goes to DONE.
- DRAIN: tmo_cnt increments each cycle with no dp_out_write and resets to 0 on a write.
  - On the NOUT-th write -> DONE.
  - If tmo_cnt reaches DRAIN_TIMEOUT -> set err.timeout and go to DONE (abort; no hang).
- DONE: ap_done=1. On ap_continue=1 (same-cycle sampling) -> FLUSH and frame_cnt++. If ap_continue is already high on entry, ap_done lasts exactly 1 cycle.
- FLUSH: dp_flush=1 for exactly 1 cycle -> IDLE. ap_start is not honoured until IDLE, so minimum frame-to-frame gap is DONE+FLUSH+IDLE = 3 cycles.
- dp_out_write in IDLE/DONE/FLUSH sets err.extra_out.
- Counter widths: in_cnt/out_cnt are CNT_W bits; frame_cnt wraps modulo 2^FRAME_W.

Test Plan:
- Nominal frame: reset, ap_start pulse, 128 samples with in_empty_n=1 and in_read_req=1, 97 dp_out_write pulses during drain, ap_continue=1 -> exactly 128 in_read; ap_ready 1 cycle after 128th read; ap_done for 1 cycle; dp_flush 1 cycle; frame_cnt=1; err=0; ap_idle=1 after.
- Back-pressure: in_empty_n toggled 50%, ap_continue held 0 for 10 cycles after done -> in_read only when empty_n=1; ap_done held 10+ cycles; no FLUSH until ap_continue.
- Timeout: stop dp_out_write after 90 outputs -> after 64 idle cycles err=4'b1000, state DONE, ap_done=1.
- Protocol errors: dp_out_write with out_full_n=0 -> err[0]=1; 98th write -> err[2]=1; write in IDLE -> err[2]=1; errors persist across frames until ap_rst.
- Coincident events: NIN-th read and NOUT-th write in same cycle (NIN=NOUT=4 config) -> ap_ready pulse, direct RUN->DONE, DRAIN skipped.
- Async reset mid-RUN after 40 reads -> immediately IDLE, ap_idle=1, in_read=0, counters 0; new ap_start runs a full clean frame.
